mem_arbiter: RTL

Shared-memory arbiter letting the risc16p instruction-fetch port and data port use a single synchronous single-port 16-bit memory. Sits between the core's I/D buses and the memory macro. Serialises accesses with a req/ack handshake: data-port priority plus a starvation limit for fetches. Optionally decodes the LED MMIO window.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_mmio.sv | 79 +++++++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the risc16p shared-memory arbiter:
//   - state_t       : arbiter FSM states (IDLE, I_WAIT, D_WAIT)
//   - LED_ADDR0/1   : byte addresses of the LED MMIO window
//   - starve_cnt_w  : width of the fetch-starvation counter for a given limit
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] LED_ADDR0 = 16'h0200;
  localparam logic [15:0] LED_ADDR1 = 16'h0202;

  // Enough bits to hold 0..max_val inclusive, never narrower than one bit.
  function automatic int starve_cnt_w(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction-fetch port, data port and memory-macro port of the
// shared-memory arbiter.
//   I port : i_req, i_addr (to arbiter); i_ack, i_rdata (from arbiter)
//   D port : d_req, d_we, d_addr, d_wdata (to arbiter); d_ack, d_rdata
//   M port : m_en, m_we, m_addr, m_wdata (from arbiter); m_rdata (to arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (core buses plus the memory macro)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-2:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/mem_arbiter_mmio.sv
// -----------------------------------------------------------------------------
// mem_arbiter_mmio
// LED register bank for the data port's MMIO window.
//   LED_ADDR0 : write sets {led_1, led_0} = wdata[15:0]; read returns same
//   LED_ADDR1 : write sets led_2 = wdata[7:0]; read returns {8'h00, led_2}
// Ports:
//   clk, rst   clock / asynchronous active-low reset
//   i_sel      D access is being issued this cycle
//   i_we       1 = write, 0 = read
//   i_addr     D byte address (bit 0 ignored)
//   i_wdata    D write data
//   o_hit      combinational: i_addr falls in the LED window
//   o_rdata    read data captured at the issue edge, valid in the ack cycle
//   o_led      {led_2, led_1, led_0}
// Only instantiated when MEM_ARBITER_MMIO_EN is defined.
// -----------------------------------------------------------------------------
module mem_arbiter_mmio
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_rdata,
  output logic [23:0]       o_led
);

  localparam logic [ADDR_W-1:0] A0 = ADDR_W'(LED_ADDR0);
  localparam logic [ADDR_W-1:0] A1 = ADDR_W'(LED_ADDR1);

  logic [ADDR_W-1:0] w_word_addr;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_unused_ok;

  logic [7:0]        r_led0;
  logic [7:0]        r_led1;
  logic [7:0]        r_led2;
  logic [DATA_W-1:0] r_rdata;

  // Accesses are whole words, so the byte-select bit takes no part in decode.
  assign w_word_addr = {i_addr[ADDR_W-1:1], 1'b0};
  assign w_unused_ok = i_addr[0];
  assign w_hit0      = (w_word_addr == A0);
  assign w_hit1      = (w_word_addr == A1);
  assign o_hit       = w_hit0 | w_hit1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led0  <= 8'h00;
      r_led1  <= 8'h00;
      r_led2  <= 8'h00;
      r_rdata <= '0;
    end else if (i_sel && o_hit) begin
      if (i_we) begin
        if (w_hit0) begin
          r_led0 <= i_wdata[7:0];
          r_led1 <= i_wdata[15:8];
        end else begin
          r_led2 <= i_wdata[7:0];
        end
      end else begin
        // Captured at the issue edge so it lines up with the memory's
        // one-cycle read latency in the ack cycle.
        r_rdata <= w_hit0 ? DATA_W'({r_led1, r_led0}) : DATA_W'({8'h00, r_led2});
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_led   = {r_led2, r_led1, r_led0};

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Lets the risc16p instruction-fetch (I) and data (D) ports share one
// synchronous single-port memory. One access is issued per two cycles: the
// grant is decided combinationally in IDLE and drives the memory strobe in
// that same cycle, then the following cycle (I_WAIT / D_WAIT) pulses the ack
// with the memory's read data. D has priority unless I has been passed over
// STARVE_MAX times in a row while requesting.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   mem_arbiter_if.slave (I port, D port, memory port)
//   led   {led_2, led_1, led_0}
// Parameters: ADDR_W / DATA_W must match the connected interface; STARVE_MAX
// is the number of consecutive D grants tolerated while I waits.
// Optional feature macro: MEM_ARBITER_MMIO_EN (LED MMIO window on the D port).
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic [23:0]  led
);

  localparam int             SCW        = starve_cnt_w(STARVE_MAX);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  state_t            r_state;
  state_t            w_state_next;
  logic [SCW-1:0]    r_starve;
  logic [SCW-1:0]    w_starve_next;
  logic              r_d_mmio;

  logic              w_starved;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_d_mmio;
  logic [DATA_W-1:0] w_mmio_rdata;
  logic              w_unused_ok;

  // Byte-select bits are dropped on the way to the word-addressed memory.
  assign w_unused_ok = bus.i_addr[0] ^ bus.d_addr[0];

  // ---------------------------------------------------------------------------
  // Grant decision (meaningful only in IDLE)
  // ---------------------------------------------------------------------------
  assign w_starved = (r_starve == STARVE_LIM);
  assign w_grant_i = (r_state == IDLE) && bus.i_req && (!bus.d_req || w_starved);
  assign w_grant_d = (r_state == IDLE) && bus.d_req && !w_grant_i;

  // ---------------------------------------------------------------------------
  // Optional LED MMIO window
  // ---------------------------------------------------------------------------
`ifdef MEM_ARBITER_MMIO_EN
  mem_arbiter_mmio #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mmio (
    .clk     (clk),
    .rst     (rst),
    .i_sel   (w_grant_d),
    .i_we    (bus.d_we),
    .i_addr  (bus.d_addr),
    .i_wdata (bus.d_wdata),
    .o_hit   (w_d_mmio),
    .o_rdata (w_mmio_rdata),
    .o_led   (led)
  );
`else
  assign w_d_mmio     = 1'b0;
  assign w_mmio_rdata = '0;
  assign led          = 24'h0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_state_next = I_WAIT;
        end else if (w_grant_d) begin
          w_state_next = D_WAIT;
        end
      end
      I_WAIT:  w_state_next = IDLE;
      D_WAIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.i_ack   = 1'b0;
    bus.i_rdata = '0;
    bus.d_ack   = 1'b0;
    bus.d_rdata = '0;
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          bus.m_en   = 1'b1;
          bus.m_addr = bus.i_addr[ADDR_W-1:1];
        end else if (w_grant_d && !w_d_mmio) begin
          bus.m_en    = 1'b1;
          bus.m_we    = bus.d_we;
          bus.m_addr  = bus.d_addr[ADDR_W-1:1];
          bus.m_wdata = bus.d_wdata;
        end
      end
      I_WAIT: begin
        bus.i_ack   = 1'b1;
        bus.i_rdata = bus.m_rdata;
      end
      D_WAIT: begin
        bus.d_ack   = 1'b1;
        bus.d_rdata = r_d_mmio ? w_mmio_rdata : bus.m_rdata;
      end
      default: ;
    endcase
    // The grant path is combinational from the requests, so the memory port
    // must be explicitly silenced while reset is held.
    if (!rst) begin
      bus.m_en    = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Remember whether the in-flight D access targets MMIO, for the read mux
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_mmio <= 1'b0;
    end else if (w_grant_d) begin
      r_d_mmio <= w_d_mmio;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch-starvation counter: counts D grants that pass over a waiting fetch
  // ---------------------------------------------------------------------------
  always_comb begin
    w_starve_next = r_starve;
    if (!bus.i_req || w_grant_i) begin
      w_starve_next = '0;
    end else if (w_grant_d && !w_starved) begin
      w_starve_next = r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_next;
    end
  end

endmodule
